// File: rtl/saradc_pkg.sv
// Shared types and width helpers for the SAR ADC sequencer.
// Both helper functions return at least 1, so the counter and index registers are never zero-width.
package saradc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SAMPLE,
        HOLD,
        BRK,
        SETTLE,
        STROBE,
        DECIDE,
        RBRK_BIT,
        FIN,
        ABRT,
        RBRK
    } sar_state_e;

    // Width of the shared sample/settle down-counter.
    function automatic int cnt_width(input int sample_cycles, input int settle_cycles);
        int m;
        m = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Width of the bit index.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/saradc_swdrv.sv
// One analog switch gate pair: S and SB are separate flops, so SB never comes from a gate.
// Reset leaves the switch off (S=0, SB=1).
module saradc_swdrv (
    input  logic clk,
    input  logic rst_n,
    input  logic on,
    output logic s,
    output logic sb
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= 1'b0;
            sb <= 1'b1;
        end else begin
            s  <= on;
            sb <= ~on;
        end
    end

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR sequencer: sample, hold, then an MSB-first binary search with break-before-make switching.
// Every output is registered; the flops are loaded from the next-state decode.
module saradc_sar_ctrl
    import saradc_pkg::*;
#(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         cmp,
    output logic         cmp_en,
    output logic         samp_s,
    output logic         samp_sb,
    output logic [N-1:0] swp_s,
    output logic [N-1:0] swp_sb,
    output logic [N-1:0] swn_s,
    output logic [N-1:0] swn_sb,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] dout
);

    localparam int CW = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int KW = idx_width(N);

    sar_state_e    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [KW-1:0] k_reg, k_next;
    logic [N-1:0]  result_reg, result_next;
    logic          cmp_en_reg, busy_reg, done_reg;
    logic [N-1:0]  dout_reg;
    logic [N-1:0]  swp_on, swn_on;
    logic          samp_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RBRK;
            cnt_reg    <= '0;
            k_reg      <= '0;
            result_reg <= '0;
            cmp_en_reg <= 1'b0;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
            dout_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            k_reg      <= k_next;
            result_reg <= result_next;
            cmp_en_reg <= (state_next == STROBE);
            busy_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == FIN);
            if (state_next == FIN) begin
                dout_reg <= result_next;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        k_next      = k_reg;
        result_next = result_reg;
        if (state_reg != IDLE && abort) begin
            state_next = ABRT;
        end else begin
            case (state_reg)
                RBRK: state_next = IDLE;
                IDLE: begin
                    if (start) begin
                        state_next  = SAMPLE;
                        cnt_next    = CW'(SAMPLE_CYCLES - 1);
                        result_next = '0;
                    end
                end
                SAMPLE: begin
                    if (cnt_reg == '0) state_next = HOLD;
                    else               cnt_next   = cnt_reg - CW'(1);
                end
                HOLD: begin
                    k_next     = KW'(N - 1);
                    state_next = BRK;
                end
                BRK: begin
                    state_next = SETTLE;
                    cnt_next   = CW'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (cnt_reg == '0) state_next = STROBE;
                    else               cnt_next   = cnt_reg - CW'(1);
                end
                STROBE: state_next = DECIDE;
                DECIDE: begin
                    result_next[k_reg] = cmp;
                    if (!cmp) begin
                        state_next = RBRK_BIT;
                    end else if (k_reg == '0) begin
                        state_next = FIN;
                    end else begin
                        k_next     = k_reg - KW'(1);
                        state_next = BRK;
                    end
                end
                RBRK_BIT: begin
                    if (k_reg == '0) begin
                        state_next = FIN;
                    end else begin
                        k_next     = k_reg - KW'(1);
                        state_next = BRK;
                    end
                end
                FIN:     state_next = IDLE;
                ABRT:    state_next = IDLE;
                default: state_next = RBRK;
            endcase
        end
    end

    // Decided bits follow the result; the bit under test is off in BRK/RBRK_BIT, so a rejected
    // bit regains its N side one cycle after RBRK_BIT, when it has become a decided bit.
    always_comb begin
        swp_on  = '0;
        swn_on  = '0;
        samp_on = (state_next == SAMPLE);
        case (state_next)
            IDLE, SAMPLE, HOLD: swn_on = '1;
            BRK, SETTLE, STROBE, DECIDE, RBRK_BIT: begin
                for (int i = 0; i < N; i++) begin
                    if (i > int'(k_next)) begin
                        swp_on[i] = result_next[i];
                        swn_on[i] = ~result_next[i];
                    end else if (i < int'(k_next)) begin
                        swn_on[i] = 1'b1;
                    end else if (state_next == SETTLE || state_next == STROBE ||
                                 state_next == DECIDE) begin
                        swp_on[i] = 1'b1;
                    end
                end
            end
            default: begin
                swp_on = '0;
                swn_on = '0;
            end
        endcase
    end

    saradc_swdrv u_samp (
        .clk   (clk),
        .rst_n (rst_n),
        .on    (samp_on),
        .s     (samp_s),
        .sb    (samp_sb)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            saradc_swdrv u_swp (
                .clk   (clk),
                .rst_n (rst_n),
                .on    (swp_on[gi]),
                .s     (swp_s[gi]),
                .sb    (swp_sb[gi])
            );
            saradc_swdrv u_swn (
                .clk   (clk),
                .rst_n (rst_n),
                .on    (swn_on[gi]),
                .s     (swn_s[gi]),
                .sb    (swn_sb[gi])
            );
        end
    endgenerate

    assign cmp_en = cmp_en_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign dout   = dout_reg;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Directed bench for saradc_sar_ctrl (N=4): an ideal comparator, a scoreboard of expected codes
// and DONE cycles, and per-cycle switch invariant checks.
module tb_saradc_sar_ctrl;

    localparam int N  = 4;
    localparam int SC = 2;
    localparam int ST = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cmp;
    logic         cmp_en, samp_s, samp_sb, busy, done;
    logic [N-1:0] swp_s, swp_sb, swn_s, swn_sb, dout;
    logic [N-1:0] vin = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int code;
        int cyc;
    } sb_item_t;
    sb_item_t exp_q[$];
    sb_item_t mon_item;

    logic [N-1:0] prev_swp = '0;
    logic [N-1:0] prev_swn = '0;

    saradc_sar_ctrl #(
        .N             (N),
        .SAMPLE_CYCLES (SC),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cmp     (cmp),
        .cmp_en  (cmp_en),
        .samp_s  (samp_s),
        .samp_sb (samp_sb),
        .swp_s   (swp_s),
        .swp_sb  (swp_sb),
        .swn_s   (swn_s),
        .swn_sb  (swn_sb),
        .busy    (busy),
        .done    (done),
        .dout    (dout)
    );

    // Ideal comparator against the DAC code formed by the P-side switches.
    assign cmp = (vin >= swp_s);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference successive approximation: resulting code and number of rejected bits.
    function automatic void ref_sar(input int v, output int code, output int rej);
        code = 0;
        rej  = 0;
        for (int b = N - 1; b >= 0; b--) begin
            if (v >= (code | (1 << b))) code = code | (1 << b);
            else                        rej++;
        end
    endfunction

    // Scoreboard consumer: every DONE must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 32'd0);
            end else begin
                mon_item = exp_q.pop_front();
                $display("txn: dout=%0h expected=%0h done_cyc=%0d expected_cyc=%0d",
                         dout, mon_item.code, cyc, mon_item.cyc);
                check("dout", dout, mon_item.code);
                check("done_cycle", cyc, mon_item.cyc);
                check("fin_switches_off", {swp_s, swn_s}, 32'd0);
            end
        end
    end

    // Switch invariants, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("pair_complement", {samp_s ^ samp_sb, swp_s ^ swp_sb, swn_s ^ swn_sb},
                  32'((1 << (2 * N + 1)) - 1));
            check("no_short", swp_s & swn_s, 32'd0);
            check("break_before_make",
                  ((swp_s & ~prev_swp) | (swn_s & ~prev_swn)) & (prev_swp | prev_swn), 32'd0);
        end
        prev_swp <= swp_s;
        prev_swn <= swn_s;
    end

    task automatic launch(input int v, input bit expect_result);
        int code, rej;
        sb_item_t it;
        vin = N'(v);
        ref_sar(v, code, rej);
        @(negedge clk);
        if (expect_result) begin
            it.code = code;
            it.cyc  = cyc + SC + N * (3 + ST) + rej + 2;
            exp_q.push_back(it);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 32'd1);
    endtask

    task automatic convert(input int v, input string tag);
        launch(v, 1'b1);
        wait_done(tag);
        @(negedge clk);
        check({tag, "_idle"}, {busy, swn_s}, {1'b0, {N{1'b1}}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_samp", {samp_s, samp_sb}, 32'b01);
        check("rst_swp", {swp_s, swp_sb}, {{N{1'b0}}, {N{1'b1}}});
        check("rst_swn", {swn_s, swn_sb}, {{N{1'b0}}, {N{1'b1}}});
        check("rst_ctrl", {cmp_en, busy, done}, 32'b010);
        check("rst_dout", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rbrk", {busy, samp_s, swp_s, swn_s}, {1'b0, 1'b0, {N{1'b0}}, {N{1'b1}}});

        convert(15, "conv_15");
        convert(10, "conv_10");

        // Abort during SETTLE of bit 2.
        launch(5, 1'b0);
        begin
            int n = 0;
            while (swp_s[2] !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("reach_settle_b2", swp_s[2], 32'd1);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abrt_all_off", {samp_s, swp_s, swn_s}, 32'd0);
        check("abrt_busy", {busy, done}, 32'b10);
        @(negedge clk);
        check("abrt_idle", {busy, swn_s}, {1'b0, {N{1'b1}}});
        check("abrt_dout_kept", dout, 32'd10);
        repeat (3) @(negedge clk);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ignored", {busy, swn_s}, {1'b0, {N{1'b1}}});

        convert(0, "conv_0");

        // Reset dropped mid-SAMPLE.
        launch(7, 1'b0);
        check("in_sample", samp_s, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_s", {samp_s, swp_s, swn_s}, 32'd0);
        check("async_rst_sb", {samp_sb, swp_sb, swn_sb}, 32'((1 << (2 * N + 1)) - 1));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rbrk_after_rel", {busy, swn_s}, {1'b1, {N{1'b0}}});
        @(negedge clk);
        check("idle_after_rel", {busy, swn_s, dout}, {1'b0, {N{1'b1}}, {N{1'b0}}});

        // START during BUSY and on the DONE cycle are both ignored.
        launch(6, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("conv_6");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_ignored", busy, 32'd0);
        @(negedge clk);
        check("still_idle", {busy, samp_s}, 32'd0);
        convert(9, "conv_9");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
